mc_cache_dma_arbiter: RTL



---
 rtl/mc_cache_dma_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mc_cache_dma_arbiter.sv
// Round-robin arbiter sharing one cache DMA channel among num_req_p requesters.
// Each grant covers one packet plus block_size_in_words_p data beats; the grant
// is released only after the final beat. All steering is combinational.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   dma_pkt_i/_v_i/_yumi_o  per-requester packet channel {write_not_read, addr}
//   dma_data_o/_v_o         per-requester fill data (downstream -> requester)
//   dma_data_ready_i        per-requester fill ready
//   dma_data_i/_v_i/_yumi_o per-requester evict data (requester -> downstream)
//   m_dma_pkt_o/_v_o/_yumi_i       downstream packet channel
//   m_dma_data_i/_v_i/_ready_o     downstream fill channel
//   m_dma_data_o/_v_o/_yumi_i      downstream evict channel
module mc_cache_dma_arbiter #(
  parameter int unsigned num_req_p             = 4,
  parameter int unsigned addr_width_p          = 32,
  parameter int unsigned data_width_p          = 32,
  parameter int unsigned block_size_in_words_p = 8,
  localparam int unsigned dma_pkt_width_lp     = addr_width_p + 1
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,

  input  logic [num_req_p-1:0][dma_pkt_width_lp-1:0]   dma_pkt_i,
  input  logic [num_req_p-1:0]                         dma_pkt_v_i,
  output logic [num_req_p-1:0]                         dma_pkt_yumi_o,

  output logic [num_req_p-1:0][data_width_p-1:0]       dma_data_o,
  output logic [num_req_p-1:0]                         dma_data_v_o,
  input  logic [num_req_p-1:0]                         dma_data_ready_i,

  input  logic [num_req_p-1:0][data_width_p-1:0]       dma_data_i,
  input  logic [num_req_p-1:0]                         dma_data_v_i,
  output logic [num_req_p-1:0]                         dma_data_yumi_o,

  output logic [dma_pkt_width_lp-1:0]                  m_dma_pkt_o,
  output logic                                         m_dma_pkt_v_o,
  input  logic                                         m_dma_pkt_yumi_i,

  input  logic [data_width_p-1:0]                      m_dma_data_i,
  input  logic                                         m_dma_data_v_i,
  output logic                                         m_dma_data_ready_o,

  output logic [data_width_p-1:0]                      m_dma_data_o,
  output logic                                         m_dma_data_v_o,
  input  logic                                         m_dma_data_yumi_i
);

  localparam int unsigned lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned cnt_w_lp  = $clog2(block_size_in_words_p + 1);

  localparam logic [lg_req_lp-1:0] last_rst_lp  = lg_req_lp'(num_req_p - 1);
  localparam logic [cnt_w_lp-1:0]  last_beat_lp = cnt_w_lp'(block_size_in_words_p - 1);

  typedef enum logic [1:0] {IDLE, PKT, FILL, EVICT} state_e;

  state_e                r_state, w_state_nxt;
  logic [lg_req_lp-1:0]  r_last,  w_last_nxt;
  logic [lg_req_lp-1:0]  r_id,    w_id_nxt;
  logic [cnt_w_lp-1:0]   r_cnt,   w_cnt_nxt;

  logic                  w_found;
  logic [lg_req_lp-1:0]  w_winner;
  logic                  w_last_beat;

  // Requester index at rotating offset off from base, wrapping at num_req_p.
  function automatic logic [lg_req_lp-1:0] rr_idx(input logic [lg_req_lp-1:0] base,
                                                   input int unsigned off);
    return lg_req_lp'((32'(base) + off) % num_req_p);
  endfunction

  // Round-robin pick: search starts just after the last granted requester.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    for (int unsigned i = 1; i <= num_req_p; i++) begin
      if (!w_found && dma_pkt_v_i[rr_idx(r_last, i)]) begin
        w_found  = 1'b1;
        w_winner = rr_idx(r_last, i);
      end
    end
  end

  // Fill data is broadcast; only the granted requester sees a valid.
  assign dma_data_o   = {num_req_p{m_dma_data_i}};
  assign m_dma_pkt_o  = dma_pkt_i[r_id];
  assign m_dma_data_o = dma_data_i[r_id];
  assign w_last_beat  = (r_cnt == last_beat_lp);

  // State register and grant bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_last  <= last_rst_lp;
      r_id    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_id    <= w_id_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic and handshake steering.
  always_comb begin
    w_state_nxt        = r_state;
    w_last_nxt         = r_last;
    w_id_nxt           = r_id;
    w_cnt_nxt          = r_cnt;
    dma_pkt_yumi_o     = '0;
    dma_data_v_o       = '0;
    dma_data_yumi_o    = '0;
    m_dma_pkt_v_o      = 1'b0;
    m_dma_data_ready_o = 1'b0;
    m_dma_data_v_o     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_id_nxt    = w_winner;
          w_state_nxt = PKT;
        end
      end

      PKT: begin
        m_dma_pkt_v_o        = dma_pkt_v_i[r_id];
        dma_pkt_yumi_o[r_id] = m_dma_pkt_yumi_i;
        if (m_dma_pkt_yumi_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = dma_pkt_i[r_id][dma_pkt_width_lp-1] ? EVICT : FILL;
        end
      end

      FILL: begin
        dma_data_v_o[r_id] = m_dma_data_v_i;
        m_dma_data_ready_o = dma_data_ready_i[r_id];
        if (m_dma_data_v_i && dma_data_ready_i[r_id]) begin
          w_cnt_nxt = r_cnt + cnt_w_lp'(1);
          if (w_last_beat) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_id;
          end
        end
      end

      EVICT: begin
        m_dma_data_v_o        = dma_data_v_i[r_id];
        dma_data_yumi_o[r_id] = m_dma_data_yumi_i;
        if (m_dma_data_yumi_i) begin
          w_cnt_nxt = r_cnt + cnt_w_lp'(1);
          if (w_last_beat) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_id;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
